// File: rtl/tournament_selector_table.sv
// Tournament chooser table: one saturating counter per index choosing the global or the local predictor.
// An initialisation walk after reset loads INIT_VAL into every entry, one per cycle.
module tournament_selector_table #(
    parameter int IDX_BITS = 6,
    parameter int CTR_BITS = 2,
    parameter int INIT_VAL = 2**(CTR_BITS-1)-1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rd_en,
    input  logic [IDX_BITS-1:0] rd_idx,
    output logic [CTR_BITS-1:0] rd_ctr,
    output logic                rd_use_global,
    input  logic                upd_en,
    input  logic [IDX_BITS-1:0] upd_idx,
    input  logic                upd_taken,
    input  logic                upd_local_pred,
    input  logic                upd_global_pred,
    output logic [CTR_BITS-1:0] upd_ctr_new,
    output logic                init_busy
);
    localparam int DEPTH = 1 << IDX_BITS;
    localparam logic [CTR_BITS-1:0] INIT_C  = CTR_BITS'(INIT_VAL);
    localparam logic [CTR_BITS-1:0] CTR_MAX = '1;
    localparam logic [IDX_BITS-1:0] LAST    = '1;

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t                state, state_next;
    logic [IDX_BITS-1:0]   walk_ptr;
    logic [CTR_BITS-1:0]   table_q [DEPTH];
    logic [CTR_BITS-1:0]   stored, trained, rd_next;
    logic                  busy;

    // Table contents are meaningless until the walk completes, so reset forces busy too.
    assign busy      = rst || (state == ST_INIT);
    assign init_busy = busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_INIT;
            walk_ptr <= '0;
        end else begin
            state <= state_next;
            if (state == ST_INIT && walk_ptr != LAST)
                walk_ptr <= walk_ptr + 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_INIT: if (walk_ptr == LAST) state_next = ST_RUN;
            ST_RUN:  state_next = ST_RUN;
            default: state_next = ST_INIT;
        endcase
    end

    always_comb begin
        stored  = table_q[upd_idx];
        trained = stored;
        if (upd_local_pred != upd_global_pred) begin
            if (upd_global_pred == upd_taken)
                trained = (stored == CTR_MAX) ? stored : stored + 1'b1;
            else
                trained = (stored == '0) ? stored : stored - 1'b1;
        end
        upd_ctr_new = busy ? INIT_C : trained;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == ST_INIT)
                table_q[walk_ptr] <= INIT_C;
            else if (upd_en)
                table_q[upd_idx] <= upd_ctr_new;
        end
    end

    // Same-index update in the same cycle is forwarded so the lookup never sees a stale entry.
    always_comb begin
        if (busy)
            rd_next = INIT_C;
        else if (upd_en && rd_idx == upd_idx)
            rd_next = upd_ctr_new;
        else
            rd_next = table_q[rd_idx];
    end

    always_ff @(posedge clk) begin
        if (rst)
            rd_ctr <= INIT_C;
        else if (rd_en)
            rd_ctr <= rd_next;
    end

    assign rd_use_global = rd_ctr[CTR_BITS-1];

endmodule
